// File: rtl/instruction_fetch_phase.sv
// MIPS IF stage: PC register, next-PC selection and the IF/ID pipeline register.
// Redirects flush IF/ID to a bubble; stalls from the hazard unit freeze PC and optionally IF/ID.
module instruction_fetch_phase #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        IF_IDWrite,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        JumpRegister,
  input  logic [31:0] JumpRegTarget,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;
  logic        redirect_s;

  // Redirect target selection: jr beats j beats branch.
  always_comb begin
    target_s   = BranchTarget;
    redirect_s = JumpRegister | Jump | Branch;
    if (JumpRegister) begin
      target_s = JumpRegTarget;
    end else if (Jump) begin
      target_s = JumpTarget;
    end else begin
      target_s = BranchTarget;
    end
  end

  // Next-state for PC and IF/ID; redirects are only honoured while the PC may advance.
  always_comb begin
    pc_plus4_s = pc_q + 32'd4;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pcp4_d     = pcp4_q;
    valid_d    = valid_q;
    if (PCWrite && redirect_s) begin
      pc_d    = {target_s[31:2], 2'b00};
      instr_d = NOP_WORD;
      pcp4_d  = 32'd0;
      valid_d = 1'b0;
    end else begin
      if (PCWrite) begin
        pc_d = pc_plus4_s;
      end else begin
        pc_d = pc_q;
      end
      if (IF_IDWrite) begin
        instr_d = imem_data;
        pcp4_d  = pc_plus4_s;
        valid_d = 1'b1;
      end else begin
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
      end
    end
  end

  // PC register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID pipeline register bank.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      instr_q <= NOP_WORD;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign instr_out = instr_q;
  assign pc_out    = pcp4_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_instruction_fetch_phase.sv
// Directed plus randomized bench for instruction_fetch_phase against a
// transaction-level model of the fetch stage kept in plain variables.
module tb_instruction_fetch_phase;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  logic        Clk;
  logic        Reset;
  logic        PCWrite;
  logic        IF_IDWrite;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        JumpRegister;
  logic [31:0] JumpRegTarget;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;

  int n_vec;
  int n_err;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcout;
  logic        m_valid;

  instruction_fetch_phase #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
    .Branch(Branch), .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .JumpRegister(JumpRegister), .JumpRegTarget(JumpRegTarget), .imem_data(imem_data),
    .imem_addr(imem_addr), .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Address-derived memory content, never equal to the NOP word for aligned addresses.
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_data = word(imem_addr);

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_instr = NOP_WORD;
    m_pcout = 32'd0;
    m_valid = 1'b0;
  endtask

  // One clock edge of the fetch stage, written from its architectural rules.
  task automatic model_edge();
    logic [31:0] seq;
    logic [31:0] tgt;
    seq = m_pc + 32'd4;
    if (PCWrite && (JumpRegister || Jump || Branch)) begin
      tgt = JumpRegister ? JumpRegTarget : (Jump ? JumpTarget : BranchTarget);
      m_pc    = tgt & 32'hFFFF_FFFC;
      m_instr = NOP_WORD;
      m_pcout = 32'd0;
      m_valid = 1'b0;
    end else begin
      if (IF_IDWrite) begin
        m_instr = word(m_pc);
        m_pcout = seq;
        m_valid = 1'b1;
      end
      if (PCWrite) m_pc = seq;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".instr_out"}, instr_out, m_instr);
    chk({tag, ".pc_out"},    pc_out,    m_pcout);
    chk({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, m_valid});
  endtask

  task automatic step(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic clear_redirects();
    Branch = 1'b0; Jump = 1'b0; JumpRegister = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b0;
    PCWrite = 1'b1; IF_IDWrite = 1'b1;
    clear_redirects();
    BranchTarget = 32'd0; JumpTarget = 32'd0; JumpRegTarget = 32'd0;
    model_reset();
    #1;
    check_all("reset");
    #1 Reset = 1'b1;

    // Sequential run
    step("seq0");
    chk("seq0_pcout", pc_out, 32'h4);
    chk("seq0_valid", {31'd0, valid_out}, 32'd1);
    step("seq1");
    step("seq2");
    chk("seq2_addr", imem_addr, 32'hC);
    step("seq3");

    // Load-use stall at 0x10
    PCWrite = 1'b0; IF_IDWrite = 1'b0;
    step("stall0");
    step("stall1");
    chk("stall_addr", imem_addr, 32'h10);
    PCWrite = 1'b1; IF_IDWrite = 1'b1;
    step("resume");
    chk("resume_addr", imem_addr, 32'h14);
    step("run18");
    step("run1c");
    step("run20");

    // Branch flush
    Branch = 1'b1; BranchTarget = 32'h100;
    step("branch");
    chk("branch_addr", imem_addr, 32'h100);
    chk("branch_valid", {31'd0, valid_out}, 32'd0);
    clear_redirects();
    step("after_branch");
    chk("after_branch_pcout", pc_out, 32'h104);
    chk("after_branch_instr", instr_out, word(32'h100));

    // All three redirects together
    Branch = 1'b1; BranchTarget = 32'h100;
    Jump = 1'b1; JumpTarget = 32'h200;
    JumpRegister = 1'b1; JumpRegTarget = 32'h303;
    step("prio");
    chk("prio_addr", imem_addr, 32'h300);
    chk("prio_instr", instr_out, NOP_WORD);
    clear_redirects();
    step("after_prio");

    // Redirect while stalled is ignored
    PCWrite = 1'b0; IF_IDWrite = 1'b0;
    Jump = 1'b1; JumpTarget = 32'h400;
    step("stall_jump");
    chk("stall_jump_addr", imem_addr, 32'h304);
    chk("stall_jump_valid", {31'd0, valid_out}, 32'd1);
    PCWrite = 1'b1; IF_IDWrite = 1'b1;
    step("jump_after_stall");
    chk("jump_after_stall_addr", imem_addr, 32'h400);
    clear_redirects();

    // PC wrap and asynchronous reset
    JumpRegister = 1'b1; JumpRegTarget = 32'hFFFF_FFFF;
    step("to_top");
    chk("to_top_addr", imem_addr, 32'hFFFF_FFFC);
    clear_redirects();
    step("wrap");
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pcout", pc_out, 32'h0);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    chk("async_reset_addr", imem_addr, RESET_PC);
    Reset = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      PCWrite       = ($urandom_range(0, 9) != 0);
      IF_IDWrite    = ($urandom_range(0, 9) != 0);
      Branch        = ($urandom_range(0, 9) == 0);
      Jump          = ($urandom_range(0, 14) == 0);
      JumpRegister  = ($urandom_range(0, 19) == 0);
      BranchTarget  = $urandom();
      JumpTarget    = $urandom();
      JumpRegTarget = $urandom();
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
